// File: rtl/uart_rx_deser_if.sv
// Holding-register handshake between the RX deserializer and its consumer.
// The master side presents the word; the slave side accepts it with out_ready.
interface uart_rx_deser_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_deser.sv
// UART RX deserializer: shifts sampled bits into a word and counts bits.
// Completed words go to a one-entry holding register with sticky overrun.
module uart_rx_deser #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              edge_done,
  input  logic              samp_out,
  output logic [DATA_W-1:0] pdata,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              frame_done,
  output logic              overrun,
  input  logic              ovr_clr,
  uart_rx_deser_if.master   hs
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              shift;
  logic              last;
  logic              drain;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign shifted = {samp_out, pdata[DATA_W-1:1]};
    end else begin : g_msb
      assign shifted = {pdata[DATA_W-2:0], samp_out};
    end
  endgenerate

  assign shift = en && edge_done && !clr;
  assign last  = shift && (bit_cnt == CNT_W'(DATA_W - 1));
  assign drain = valid_q && hs.out_ready;

  assign hs.out_data  = data_q;
  assign hs.out_valid = valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pdata      <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= last;

      if (clr) begin
        pdata   <= '0;
        bit_cnt <= '0;
      end else if (shift) begin
        pdata   <= shifted;
        bit_cnt <= last ? '0 : bit_cnt + CNT_W'(1);
      end

      // A load always refills the slot, even if the old word drains now.
      if (last) begin
        data_q  <= shifted;
        valid_q <= 1'b1;
      end else if (drain) begin
        valid_q <= 1'b0;
      end

      // Set beats clear so a fresh overrun is never lost.
      if (last && valid_q && !hs.out_ready) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: three instances (8 LSB, 8 MSB, 5 LSB) checked
// every cycle against a bit-history model of the received stream.
module tb_uart_rx_deser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic clr, en, ed, s, oc, rdy;
  logic clr5, en5, ed5, s5, oc5, rdy5;

  logic [7:0] pda, pdb;
  logic [3:0] bca, bcb;
  logic       fda, fdb, ova, ovb;
  logic [4:0] pdc;
  logic [2:0] bcc;
  logic       fdc, ovc;

  uart_rx_deser_if #(.DATA_W(8)) ifa ();
  uart_rx_deser_if #(.DATA_W(8)) ifb ();
  uart_rx_deser_if #(.DATA_W(5)) ifc ();

  assign ifa.out_ready = rdy;
  assign ifb.out_ready = rdy;
  assign ifc.out_ready = rdy5;

  uart_rx_deser #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .edge_done(ed),
    .samp_out(s), .pdata(pda), .bit_cnt(bca), .frame_done(fda),
    .overrun(ova), .ovr_clr(oc), .hs(ifa)
  );

  uart_rx_deser #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .edge_done(ed),
    .samp_out(s), .pdata(pdb), .bit_cnt(bcb), .frame_done(fdb),
    .overrun(ovb), .ovr_clr(oc), .hs(ifb)
  );

  uart_rx_deser #(.DATA_W(5), .LSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .clr(clr5), .en(en5), .edge_done(ed5),
    .samp_out(s5), .pdata(pdc), .bit_cnt(bcc), .frame_done(fdc),
    .overrun(ovc), .ovr_clr(oc5), .hs(ifc)
  );

  int checks   = 0;
  int failures = 0;

  // Model: recent bits since the last clear (oldest first), per channel.
  int          W [3] = '{8, 8, 5};
  bit          L [3] = '{1'b1, 1'b0, 1'b1};
  bit          hb [3][16];
  int          hn [3];
  int          cnt[3];
  logic [15:0] md [3];
  bit          mv [3];
  bit          mo [3];
  bit          mf [3];

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pd(input int c);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < hn[c]; k++) begin
      int j;
      j = hn[c] - 1 - k;
      if (hb[c][k]) v[L[c] ? W[c] - 1 - j : j] = 1'b1;
    end
    return v;
  endfunction

  task automatic mreset();
    for (int c = 0; c < 3; c++) begin
      hn[c] = 0; cnt[c] = 0; md[c] = '0;
      mv[c] = 1'b0; mo[c] = 1'b0; mf[c] = 1'b0;
    end
  endtask

  task automatic step(input int c, input bit cl, input bit e,
                      input bit d, input bit b, input bit r,
                      input bit o);
    bit ld;
    ld = 1'b0;
    if (cl) begin
      hn[c] = 0;
      cnt[c] = 0;
    end else if (e && d) begin
      if (hn[c] == W[c]) begin
        for (int i = 0; i < W[c] - 1; i++) hb[c][i] = hb[c][i+1];
        hn[c]--;
      end
      hb[c][hn[c]] = b;
      hn[c]++;
      cnt[c]++;
      if (cnt[c] == W[c]) begin
        cnt[c] = 0;
        ld = 1'b1;
      end
    end
    if (ld && mv[c] && !r) mo[c] = 1'b1;
    else if (o) mo[c] = 1'b0;
    if (ld) begin
      mv[c] = 1'b1;
      md[c] = pd(c);
    end else if (mv[c] && r) begin
      mv[c] = 1'b0;
    end
    mf[c] = ld;
  endtask

  task automatic chk_all();
    chk("a_pdata", 16'(pda), pd(0));
    chk("a_cnt",   16'(bca), 16'(cnt[0]));
    chk("a_fd",    16'(fda), 16'(mf[0]));
    chk("a_data",  16'(ifa.out_data), md[0]);
    chk("a_valid", 16'(ifa.out_valid), 16'(mv[0]));
    chk("a_ovr",   16'(ova), 16'(mo[0]));
    chk("b_pdata", 16'(pdb), pd(1));
    chk("b_cnt",   16'(bcb), 16'(cnt[1]));
    chk("b_fd",    16'(fdb), 16'(mf[1]));
    chk("b_data",  16'(ifb.out_data), md[1]);
    chk("b_valid", 16'(ifb.out_valid), 16'(mv[1]));
    chk("b_ovr",   16'(ovb), 16'(mo[1]));
    chk("c_pdata", 16'(pdc), pd(2));
    chk("c_cnt",   16'(bcc), 16'(cnt[2]));
    chk("c_fd",    16'(fdc), 16'(mf[2]));
    chk("c_data",  16'(ifc.out_data), md[2]);
    chk("c_valid", 16'(ifc.out_valid), 16'(mv[2]));
    chk("c_ovr",   16'(ovc), 16'(mo[2]));
  endtask

  task automatic cyc();
    step(0, clr, en, ed, s, rdy, oc);
    step(1, clr, en, ed, s, rdy, oc);
    step(2, clr5, en5, ed5, s5, rdy5, oc5);
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic send8(input bit b, input int gap);
    repeat (gap) cyc();
    en = 1'b1; ed = 1'b1; s = b;
    cyc();
    ed = 1'b0;
  endtask

  task automatic word8(input logic [7:0] w, input int gap);
    for (int i = 0; i < 8; i++) send8(w[i], gap);
  endtask

  initial begin
    bit bits [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    bit b5   [5] = '{1, 1, 0, 0, 1};
    bit r5   [5] = '{1, 0, 1, 0, 1};
    logic [7:0] w96;

    {clr, en, ed, s, oc, rdy} = '0;
    {clr5, en5, ed5, s5, oc5, rdy5} = '0;
    mreset();
    #12;
    chk_all();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, strobes 16 cycles apart, no consumer.
    for (int i = 0; i < 8; i++) send8(bits[i], 15);
    chk("basic_fd", 16'(fda), 16'h1);
    chk("basic_data", 16'(ifa.out_data), 16'h4D);
    chk("basic_valid", 16'(ifa.out_valid), 16'h1);
    chk("basic_cnt", 16'(bca), 16'h0);
    chk("msb_data", 16'(ifb.out_data), 16'hB2);
    chk("msb_pdata", 16'(pdb), 16'hB2);
    cyc();
    chk("basic_fd_once", 16'(fda), 16'h0);

    // Abort after 5 bits, clear wins over a simultaneous strobe.
    for (int i = 0; i < 5; i++) send8(1'($urandom), 2);
    clr = 1'b1; ed = 1'b1; s = 1'b1;
    cyc();
    clr = 1'b0; ed = 1'b0;
    chk("abort_cnt", 16'(bca), 16'h0);
    chk("abort_pdata", 16'(pda), 16'h0);
    chk("abort_fd", 16'(fda), 16'h0);
    word8(8'hFF, 1);
    chk("abort_data", 16'(ifa.out_data), 16'hFF);
    oc = 1'b1; cyc(); oc = 1'b0;
    rdy = 1'b1; cyc(); rdy = 1'b0;

    // Handshake and overrun.
    word8(8'hA5, 0);
    word8(8'h3C, 0);
    chk("ovr_data", 16'(ifa.out_data), 16'h3C);
    chk("ovr_set", 16'(ova), 16'h1);
    oc = 1'b1; cyc(); oc = 1'b0;
    chk("ovr_clr", 16'(ova), 16'h0);
    rdy = 1'b1; cyc(); rdy = 1'b0;
    chk("accept_valid", 16'(ifa.out_valid), 16'h0);

    // Accept and load in the same cycle.
    word8(8'h5A, 0);
    w96 = 8'h96;
    for (int i = 0; i < 7; i++) send8(w96[i], 0);
    rdy = 1'b1;
    send8(w96[7], 0);
    rdy = 1'b0;
    chk("sim_valid", 16'(ifa.out_valid), 16'h1);
    chk("sim_data", 16'(ifa.out_data), 16'h96);
    chk("sim_ovr", 16'(ova), 16'h0);

    // Randomized traffic on both input groups.
    for (int n = 0; n < 600; n++) begin
      en   = ($urandom % 10) != 0;
      ed   = ($urandom % 3) == 0;
      s    = 1'($urandom);
      rdy  = ($urandom % 4) == 0;
      oc   = ($urandom % 8) == 0;
      clr  = ($urandom % 50) == 0;
      en5  = ($urandom % 10) != 0;
      ed5  = ($urandom % 2) == 0;
      s5   = 1'($urandom);
      rdy5 = ($urandom % 3) == 0;
      oc5  = ($urandom % 8) == 0;
      clr5 = ($urandom % 40) == 0;
      cyc();
    end
    {clr, en, ed, s, oc, rdy} = '0;
    {clr5, en5, ed5, s5, oc5, rdy5} = '0;
    cyc();
    clr5 = 1'b1; clr = 1'b1; cyc();
    clr5 = 1'b0; clr = 1'b0;
    rdy5 = 1'b1; cyc(); rdy5 = 1'b0;

    // Back-to-back strobes on the 5-bit instance.
    en5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ed5 = 1'b1; s5 = b5[i];
      cyc();
      if (i < 4) chk("c_fd_early", 16'(fdc), 16'h0);
    end
    ed5 = 1'b0;
    chk("c_fd", 16'(fdc), 16'h1);
    chk("c_data", 16'(ifc.out_data), 16'h13);

    // Asynchronous reset mid-frame.
    ed5 = 1'b1; s5 = 1'b1; cyc(); cyc();
    ed5 = 1'b0;
    send8(1'b1, 0); send8(1'b0, 0);
    #2;
    rst = 1'b0;
    #1;
    mreset();
    chk_all();
    chk("rst_pdata", 16'(pdc), 16'h0);
    chk("rst_valid", 16'(ifc.out_valid), 16'h0);
    chk("rst_cnt", 16'(bca), 16'h0);
    {clr, en, ed, s, oc, rdy} = '0;
    {clr5, en5, ed5, s5, oc5, rdy5} = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    en5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ed5 = 1'b1; s5 = r5[i];
      cyc();
    end
    ed5 = 1'b0;
    chk("post_rst_data", 16'(ifc.out_data), 16'h15);
    chk("post_rst_fd", 16'(fdc), 16'h1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Parametrised receive deserializer for the UART-to-APB bridge. It sits between the RX bit sampler and the RX frame FSM. It shifts sampled bits into a configurable-width word in either bit order and counts bits per frame. Each completed word is delivered through a one-entry valid/ready holding register, with sticky overrun detection.

## Interface
Parameters:
- DATA_W, 8: bits per frame, legal range 2..16.
- LSB_FIRST, 1: 1 = first received bit lands in pdata[0] (UART order); 0 = first bit lands in pdata[DATA_W-1] (left-shift order).
- CNT_W, $clog2(DATA_W+1): bit counter width, derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous frame abort/restart, pulsed by the FSM on start-bit detect.
- en  in  1  data-phase enable from the FSM.
- edge_done  in  1  one-cycle strobe: samp_out is valid this cycle.
- samp_out  in  1  sampled serial bit.
- pdata  out  DATA_W  live shift register.
- bit_cnt  out  CNT_W  bits captured in the current frame, 0..DATA_W-1.
- frame_done  out  1  one-cycle pulse when a word completes.
- out_data  out  DATA_W  holding register.
- out_valid  out  1  holding register full.
- out_ready  in  1  consumer accepts out_data.
- overrun  out  1  sticky: a completed word arrived while the holding register was full and not being drained.
- ovr_clr  in  1  synchronous clear of overrun.

## Operation
- Shift event: en && edge_done && !clr.
  - LSB_FIRST=1: pdata <= {samp_out, pdata[DATA_W-1:1]}.
  - LSB_FIRST=0: pdata <= {pdata[DATA_W-2:0], samp_out}.
- bit_cnt increments on each shift event.
- Last-bit shift event (bit_cnt == DATA_W-1), all in the same clock edge:
  - bit_cnt <= 0.
  - pdata <= shifted value.
  - out_data <= shifted value, including the final bit.
  - out_valid <= 1.
  - frame_done <= 1.
- Accept: out_valid && out_ready causes out_valid <= 0 on the next edge, unless a load occurs in the same cycle.
- Load with out_valid=1 and out_ready=1 in the same cycle:
  - The old word is consumed and the new word loaded.
  - out_valid stays 1; no overrun.
- Load with out_valid=1 and out_ready=0:
  - The new word overwrites out_data.
  - out_valid stays 1.
  - overrun <= 1.
- overrun holds until ovr_clr=1. If ovr_clr and a new overrun occur in the same cycle, set wins (overrun stays 1).
- clr:
  - pdata <= 0 and bit_cnt <= 0; no frame_done.
  - clr beats a simultaneous shift event; that bit is discarded.
  - out_data, out_valid and overrun are unaffected.
- en=0 or edge_done=0: pdata and bit_cnt hold.
- en=1 alone never shifts; edge_done is required.

## Timing
- Reset values: pdata=0, bit_cnt=0, frame_done=0, out_data=0, out_valid=0, overrun=0.
- All outputs are registered; no combinational input-to-output paths.
- Latency: frame_done, out_valid and out_data update on the edge that captures the last bit. They are visible 1 cycle after the final edge_done.
- frame_done is high exactly 1 cycle per completed word.
- Back-to-back edge_done on consecutive cycles is legal, one bit per cycle.
  - Minimum frame time: DATA_W cycles.
- Reset asserted mid-frame: all state clears immediately, asynchronously. After release, the first shift event is bit 0 of a new frame.
- out_ready is sampled only while out_valid=1; it is don't-care otherwise.

## Test plan
- Reset and basic frame, DATA_W=8, LSB_FIRST=1: shift bits 1,0,1,1,0,0,1,0 (first to last) with edge_done spaced 16 cycles; out_ready=0 → frame_done pulses once, 1 cycle after the 8th strobe; out_data=0x4D; out_valid=1; bit_cnt=0.
- LSB_FIRST=0, same bit stream → out_data=0xB2; pdata=0xB2.
- Abort: 5 bits shifted, then clr pulsed together with edge_done → bit_cnt=0, pdata=0, no frame_done; the next 8 bits 0xFF (LSB first) produce out_data=0xFF.
- Handshake and overrun:
  - 0xA5 is completed; out_ready held 0 while 0x3C completes → out_data=0x3C, overrun=1.
  - ovr_clr=1 → overrun=0.
  - out_ready=1 → out_valid falls on the next edge.
- Simultaneous accept and load, with out_ready=1 on the load cycle → out_valid stays 1, out_data is the new word, overrun=0.
- DATA_W=5 with back-to-back edge_done every cycle, bits 1,1,0,0,1 (LSB first) → out_data=5'b10011, frame_done exactly 5 cycles after the first strobe; rst dropped mid-frame → all outputs 0.
